// File: rtl/osc_sequencer.sv
// Pattern sequencer: a CPU-programmed table of (threshold, duration) entries is
// played out to an oscillator through a valid/ready master port.
module osc_sequencer #(
  parameter int STEPS = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        valid,
  output logic        ready,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        osc_valid,
  input  logic        osc_ready,
  output logic [3:0]  osc_wstrb,
  output logic [31:0] osc_wdata,
  output logic [3:0]  step,
  output logic        playing
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WRITE   = 3'd1,
    ACK     = 3'd2,
    HOLD    = 3'd3,
    STOP    = 3'd4,
    ACKSTOP = 3'd5
  } state_t;

  localparam logic [3:0] IDX_MASK = 4'(STEPS - 1);
  localparam logic [3:0] LAST_IDX = 4'(STEPS - 1);

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    end
    return res;
  endfunction

  state_t      state_r, state_nxt_s;
  logic [3:0]  step_r, step_nxt_s, step_inc_s;
  logic        natural_r, natural_nxt_s, finish_s;
  logic        run_r, loop_r, done_r;
  logic [15:0] tickdiv_r, tdiv_r, tick_r;
  logic [7:0]  dur_r, dcnt_r, next_dur_s;
  logic        tick_end_s, hold_end_s;
  logic [31:0] entry_r [0:15];
  logic        ready_r, osc_valid_r, playing_r;
  logic [31:0] rdata_r, osc_wdata_r, rd_s, ctrl_new_s;
  logic [3:0]  osc_wstrb_r, idx_s;
  logic        wr_en_s, ctrl_wr_s, tdiv_wr_s, ent_wr_s;
  logic        unused_s;

  assign unused_s   = ^{addr[31:7], addr[1:0]};
  assign idx_s      = addr[5:2] & IDX_MASK;
  assign wr_en_s    = valid && ready_r && (wstrb != 4'd0);
  assign ctrl_wr_s  = wr_en_s && !addr[6] && (addr[5:2] == 4'd0);
  assign tdiv_wr_s  = wr_en_s && !addr[6] && (addr[5:2] == 4'd2);
  assign ent_wr_s   = wr_en_s && addr[6];
  assign ctrl_new_s = merge_bytes({30'd0, loop_r, run_r}, wdata, wstrb);

  assign step_inc_s = step_r + 4'd1;
  assign next_dur_s = entry_r[step_inc_s][31:24];
  assign tick_end_s = (tick_r == tdiv_r);
  // A zero latched duration (entry rewritten mid-play) ends after one tick.
  assign hold_end_s = tick_end_s && ((dur_r == 8'd0) || (dcnt_r == dur_r - 8'd1));

  // CPU read mux
  always_comb begin
    rd_s = 32'd0;
    if (addr[6]) begin
      rd_s = entry_r[idx_s];
    end else begin
      case (addr[5:2])
        4'd0:    rd_s = {30'd0, loop_r, run_r};
        4'd1:    rd_s = {20'd0, step_r, 6'd0, done_r, playing_r};
        4'd2:    rd_s = {16'd0, tickdiv_r};
        default: rd_s = 32'd0;
      endcase
    end
  end

  // Next-state, step and end-kind selection
  always_comb begin
    state_nxt_s   = state_r;
    step_nxt_s    = step_r;
    natural_nxt_s = natural_r;
    finish_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (run_r) begin
          step_nxt_s = 4'd0;
          if (entry_r[0][31:24] == 8'd0) begin
            state_nxt_s   = STOP;
            natural_nxt_s = 1'b1;
          end else begin
            state_nxt_s   = WRITE;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WRITE: state_nxt_s = ACK;
      ACK: begin
        if (osc_ready) begin
          if (run_r) begin
            state_nxt_s   = HOLD;
          end else begin
            state_nxt_s   = STOP;
            natural_nxt_s = 1'b0;
          end
        end else begin
          state_nxt_s = ACK;
        end
      end
      HOLD: begin
        if (!run_r) begin
          state_nxt_s   = STOP;
          natural_nxt_s = 1'b0;
        end else if (hold_end_s) begin
          if ((step_r < LAST_IDX) && (next_dur_s != 8'd0)) begin
            step_nxt_s  = step_inc_s;
            state_nxt_s = WRITE;
          end else if (loop_r && (entry_r[0][31:24] != 8'd0)) begin
            step_nxt_s  = 4'd0;
            state_nxt_s = WRITE;
          end else begin
            state_nxt_s   = STOP;
            natural_nxt_s = 1'b1;
          end
        end else begin
          state_nxt_s = HOLD;
        end
      end
      STOP: state_nxt_s = ACKSTOP;
      ACKSTOP: begin
        if (osc_ready) begin
          state_nxt_s = IDLE;
          finish_s    = 1'b1;
        end else begin
          state_nxt_s = ACKSTOP;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM state, hold counters and registered oscillator outputs
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r     <= IDLE;
      step_r      <= 4'd0;
      natural_r   <= 1'b0;
      playing_r   <= 1'b0;
      osc_valid_r <= 1'b0;
      osc_wstrb_r <= 4'd0;
      osc_wdata_r <= 32'd0;
      dur_r       <= 8'd0;
      dcnt_r      <= 8'd0;
      tick_r      <= 16'd0;
      tdiv_r      <= 16'd0;
    end else begin
      state_r     <= state_nxt_s;
      step_r      <= step_nxt_s;
      natural_r   <= natural_nxt_s;
      playing_r   <= (state_nxt_s != IDLE);
      osc_valid_r <= (state_nxt_s == WRITE) || (state_nxt_s == ACK) ||
                     (state_nxt_s == STOP)  || (state_nxt_s == ACKSTOP);
      osc_wstrb_r <= ((state_nxt_s == WRITE) || (state_nxt_s == STOP)) ? 4'hF : 4'h0;
      if (state_nxt_s == WRITE) begin
        osc_wdata_r <= {8'h00, entry_r[step_nxt_s][23:0]};
      end else if (state_nxt_s == STOP) begin
        osc_wdata_r <= 32'd0;
      end
      // Duration and divider are sampled at HOLD entry; divider again per tick.
      if ((state_nxt_s == HOLD) && (state_r != HOLD)) begin
        dur_r  <= entry_r[step_r][31:24];
        dcnt_r <= 8'd0;
        tick_r <= 16'd0;
        tdiv_r <= tickdiv_r;
      end else if (state_r == HOLD) begin
        if (tick_end_s) begin
          tick_r <= 16'd0;
          dcnt_r <= dcnt_r + 8'd1;
          tdiv_r <= tickdiv_r;
        end else begin
          tick_r <= tick_r + 16'd1;
        end
      end
    end
  end

  // CPU slave handshake and register file
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ready_r   <= 1'b0;
      rdata_r   <= 32'd0;
      run_r     <= 1'b0;
      loop_r    <= 1'b0;
      done_r    <= 1'b0;
      tickdiv_r <= 16'd0;
      for (int i = 0; i < 16; i++) begin
        entry_r[i] <= 32'd0;
      end
    end else begin
      ready_r <= valid && !ready_r;
      rdata_r <= (valid && !ready_r) ? rd_s : 32'd0;
      // CPU write to CTRL wins over the end-of-play hardware update.
      if (ctrl_wr_s) begin
        run_r  <= ctrl_new_s[0];
        loop_r <= ctrl_new_s[1];
        done_r <= 1'b0;
      end else if (finish_s) begin
        run_r  <= 1'b0;
        done_r <= natural_r;
      end
      if (tdiv_wr_s) begin
        tickdiv_r <= merge_bytes({16'd0, tickdiv_r}, wdata, wstrb) & 32'h0000_FFFF;
      end
      if (ent_wr_s) begin
        entry_r[idx_s] <= merge_bytes(entry_r[idx_s], wdata, wstrb);
      end
    end
  end

  assign ready     = ready_r;
  assign rdata     = rdata_r;
  assign osc_valid = osc_valid_r;
  assign osc_wstrb = osc_wstrb_r;
  assign osc_wdata = osc_wdata_r;
  assign step      = step_r;
  assign playing   = playing_r;

endmodule

// File: tb/tb_osc_sequencer.sv
// Directed bench for osc_sequencer: CPU register access, playback timing,
// looping, abort, slow oscillator acknowledge and mid-transaction reset.
module tb_osc_sequencer;

  logic        clk = 1'b0;
  logic        resetn, valid, ready, osc_valid, osc_ready, playing;
  logic [3:0]  wstrb, osc_wstrb, step;
  logic [31:0] addr, wdata, rdata, osc_wdata;

  osc_sequencer #(.STEPS(16)) dut (
    .clk(clk), .resetn(resetn), .valid(valid), .ready(ready), .wstrb(wstrb),
    .addr(addr), .wdata(wdata), .rdata(rdata), .osc_valid(osc_valid),
    .osc_ready(osc_ready), .osc_wstrb(osc_wstrb), .osc_wdata(osc_wdata),
    .step(step), .playing(playing)
  );

  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Oscillator responder: acknowledges after osc_dly waiting cycles.
  int osc_dly = 0;
  int ack_cnt = 0;
  always @(negedge clk) begin
    if (osc_valid && (osc_wstrb == 4'd0)) begin
      osc_ready = (ack_cnt >= osc_dly);
      ack_cnt++;
    end else begin
      osc_ready = 1'b0;
      ack_cnt = 0;
    end
  end

  // Oscillator write recorder
  int          cyc = 0, wr_n = 0, valid_cnt = 0, strb_overlap = 0;
  logic [31:0] wr_data [64];
  logic [3:0]  wr_step [64];
  logic [3:0]  wr_strb [64];
  int          wr_cyc  [64];
  logic [3:0]  prev_strb = 4'd0;
  always @(negedge clk) begin
    cyc++;
    if (osc_valid) valid_cnt++;
    if (osc_wstrb != 4'd0) begin
      if (prev_strb != 4'd0) strb_overlap++;
      if (wr_n < 64) begin
        wr_data[wr_n] = osc_wdata;
        wr_step[wr_n] = step;
        wr_strb[wr_n] = osc_wstrb;
        wr_cyc[wr_n]  = cyc;
      end
      wr_n++;
    end
    prev_strb = osc_wstrb;
  end

  task automatic cpu_xfer(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [31:0] rd, output int lat);
    @(negedge clk);
    valid = 1'b1; addr = a; wdata = d; wstrb = s;
    lat = 0; rd = 32'd0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (ready) begin
        lat = i;
        rd = rdata;
        break;
      end
    end
    @(posedge clk); #1;
    valid = 1'b0; wstrb = 4'd0;
    @(negedge clk);
    check_vec("ready_pulse", {31'd0, ready}, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic cpu_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] rd;
    int lat;
    cpu_xfer(a, d, s, rd, lat);
    check_vec("wr_latency", 32'(lat), 32'd1);
  endtask

  task automatic cpu_read(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] rd;
    int lat;
    cpu_xfer(a, 32'd0, 4'd0, rd, lat);
    check_vec("rd_latency", 32'(lat), 32'd1);
    check_vec(tag, rd, exp);
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while (!playing && n < 10) begin @(negedge clk); n++; end
    n = 0;
    while (playing && n < limit) begin @(negedge clk); n++; end
    check_vec("idle_timeout", {31'd0, playing}, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int base, vbase;
    resetn = 1'b0; valid = 1'b0; wstrb = 4'd0; addr = 32'd0; wdata = 32'd0;
    osc_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_vec("rst_ready", {31'd0, ready}, 32'd0);
    check_vec("rst_rdata", rdata, 32'd0);
    check_vec("rst_osc_valid", {31'd0, osc_valid}, 32'd0);
    check_vec("rst_osc_wstrb", {28'd0, osc_wstrb}, 32'd0);
    check_vec("rst_osc_wdata", osc_wdata, 32'd0);
    check_vec("rst_step", {28'd0, step}, 32'd0);
    check_vec("rst_playing", {31'd0, playing}, 32'd0);
    resetn = 1'b1;
    cpu_read("rst_ctrl", 32'h00, 32'd0);
    cpu_read("rst_tickdiv", 32'h08, 32'd0);

    // Register map and byte lanes
    cpu_write(32'h4C, 32'hAABB_CCDD, 4'hF);
    cpu_write(32'h4C, 32'h1122_3344, 4'b0101);
    cpu_read("byte_lanes", 32'h4C, 32'hAA22_CC44);
    cpu_write(32'h10, 32'hFFFF_FFFF, 4'hF);
    cpu_read("unmapped", 32'h10, 32'd0);

    // Two-note natural end
    cpu_write(32'h08, 32'h0000_0003, 4'hF);
    cpu_read("tickdiv", 32'h08, 32'h0000_0003);
    cpu_write(32'h40, 32'h0200_0100, 4'hF);
    cpu_write(32'h44, 32'h0100_0080, 4'hF);
    base = wr_n;
    cpu_write(32'h00, 32'h1, 4'hF);
    wait_idle(200);
    check_vec("play_nwr", 32'(wr_n - base), 32'd3);
    check_vec("play_note0", wr_data[base], 32'h0000_0100);
    check_vec("play_strb0", {28'd0, wr_strb[base]}, 32'h0000_000F);
    check_vec("play_note1", wr_data[base+1], 32'h0000_0080);
    check_vec("play_stop", wr_data[base+2], 32'd0);
    check_vec("play_gap0", 32'(wr_cyc[base+1] - wr_cyc[base]), 32'd10);
    check_vec("play_gap1", 32'(wr_cyc[base+2] - wr_cyc[base+1]), 32'd6);
    cpu_read("play_status", 32'h04, 32'h0000_0102);
    cpu_read("play_ctrl", 32'h00, 32'd0);

    // Loop over two entries
    cpu_write(32'h08, 32'h0, 4'hF);
    cpu_write(32'h40, 32'h0100_0011, 4'hF);
    cpu_write(32'h44, 32'h0100_0022, 4'hF);
    base = wr_n;
    cpu_write(32'h00, 32'h3, 4'hF);
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (wr_n - base >= 5) break;
    end
    check_vec("loop_cnt", {31'd0, (wr_n - base >= 5)}, 32'd1);
    cpu_write(32'h00, 32'h0, 4'hF);
    wait_idle(50);
    check_vec("loop_d0", wr_data[base],   32'h11);
    check_vec("loop_d1", wr_data[base+1], 32'h22);
    check_vec("loop_d2", wr_data[base+2], 32'h11);
    check_vec("loop_d3", wr_data[base+3], 32'h22);
    check_vec("loop_s2", {28'd0, wr_step[base+2]}, 32'd0);
    check_vec("loop_s3", {28'd0, wr_step[base+3]}, 32'd1);
    check_vec("loop_last", wr_data[wr_n-1], 32'd0);

    // Abort during HOLD
    cpu_write(32'h08, 32'h9, 4'hF);
    cpu_write(32'h40, 32'h0A00_0055, 4'hF);
    cpu_write(32'h44, 32'h0, 4'hF);
    cpu_write(32'h00, 32'h1, 4'hF);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (playing && !osc_valid) break;
    end
    @(posedge clk); #1;
    base = wr_n;
    cpu_write(32'h00, 32'h0, 4'hF);
    wait_idle(50);
    check_vec("abort_nwr", 32'(wr_n - base), 32'd1);
    check_vec("abort_data", wr_data[base], 32'd0);
    cpu_read("abort_status", 32'h04, 32'd0);

    // Slow oscillator acknowledge
    osc_dly = 5;
    cpu_write(32'h08, 32'h1, 4'hF);
    cpu_write(32'h40, 32'h0100_0077, 4'hF);
    base = wr_n; vbase = valid_cnt;
    cpu_write(32'h00, 32'h1, 4'hF);
    wait_idle(100);
    check_vec("slow_nwr", 32'(wr_n - base), 32'd2);
    check_vec("slow_note", wr_data[base], 32'h77);
    check_vec("slow_gap", 32'(wr_cyc[base+1] - wr_cyc[base]), 32'd9);
    check_vec("slow_valid", 32'(valid_cnt - vbase), 32'd14);
    cpu_read("slow_status", 32'h04, 32'h0000_0002);

    // STATUS read during playback
    osc_dly = 0;
    cpu_write(32'h08, 32'h0, 4'hF);
    cpu_write(32'h40, 32'h0200_0001, 4'hF);
    cpu_write(32'h44, 32'h3200_0002, 4'hF);
    cpu_write(32'h00, 32'h1, 4'hF);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (step == 4'd1) break;
    end
    cpu_read("live_status", 32'h04, 32'h0000_0101);
    cpu_write(32'h00, 32'h0, 4'hF);
    wait_idle(50);

    // Reset asserted during ACK
    osc_dly = 5;
    cpu_write(32'h00, 32'h1, 4'hF);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (osc_valid && (osc_wstrb == 4'd0)) break;
    end
    resetn = 1'b0;
    @(negedge clk);
    check_vec("mid_rst_valid", {31'd0, osc_valid}, 32'd0);
    check_vec("mid_rst_wstrb", {28'd0, osc_wstrb}, 32'd0);
    check_vec("mid_rst_wdata", osc_wdata, 32'd0);
    check_vec("mid_rst_playing", {31'd0, playing}, 32'd0);
    check_vec("mid_rst_step", {28'd0, step}, 32'd0);
    resetn = 1'b1;
    @(posedge clk); #1;
    base = wr_n; vbase = valid_cnt;
    repeat (20) @(posedge clk);
    #1;
    check_vec("post_rst_nwr", 32'(wr_n - base), 32'd0);
    check_vec("post_rst_valid", 32'(valid_cnt - vbase), 32'd0);
    osc_dly = 0;
    cpu_read("post_rst_ctrl", 32'h00, 32'd0);
    cpu_read("post_rst_entry", 32'h40, 32'd0);

    // Entry 0 is an end marker at start
    base = wr_n;
    cpu_write(32'h00, 32'h1, 4'hF);
    wait_idle(50);
    check_vec("empty_nwr", 32'(wr_n - base), 32'd1);
    check_vec("empty_data", wr_data[base], 32'd0);
    cpu_read("empty_status", 32'h04, 32'h0000_0002);
    cpu_write(32'h00, 32'h0, 4'hF);
    cpu_read("done_clear", 32'h04, 32'd0);

    check_vec("strb_one_cycle", 32'(strb_overlap), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
